// File: rtl/rr_mux_arbiter_16_pkg.sv
// Shared constants and FSM encoding for the 16-way round-robin mux arbiter.
// No ports; imported by rr_pick16 and rr_mux_arbiter_16.
package rr_mux_arbiter_16_pkg;
    localparam int NUM_REQ      = 16;
    localparam int SEL_W        = 4;
    localparam int HOLD_W       = 4;
    localparam int MAX_HOLD_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        LOCK = 2'd2
    } state_t;
endpackage

// File: rtl/mux_16to1_32bit.sv
// 16:1 word multiplexer.
// Ports: data (16 packed words), ctrl (word index), out (selected word).
module mux_16to1_32bit #(
    parameter int W = 32
) (
    input  logic [16*W-1:0] data,
    input  logic [3:0]      ctrl,
    output logic [W-1:0]    out
);
    // Indexed part-select only reads the chosen lane.
    assign out = data[ctrl*W +: W];
endmodule

// File: rtl/rr_mux_arbiter_16_pick.sv
// rr_pick16: combinational rotating priority picker.
// Ports: req (requests), start (highest-priority index),
// idx (first set bit at or after start, mod 16), any (|req).
module rr_pick16
    import rr_mux_arbiter_16_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   start,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);
    logic [SEL_W-1:0] j;

    // Walk from the lowest priority offset up so the
    // closest set bit to start is written last and wins.
    always_comb begin
        idx = '0;
        j   = '0;
        any = |req;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = start + SEL_W'(k);
            if (req[j]) idx = j;
        end
    end
endmodule

// File: rtl/rr_mux_arbiter_16.sv
// Round-robin arbiter sharing one 16:1 word path, with optional
// bounded grant lock and registered valid/ready output.
// Ports: clk, rst_n (async low), req, lock, req_data (16 packed words),
// gnt (one-hot, combinational), out_sel, out_data, out_valid, out_ready.
// Macro ARB_STATS_EN adds beat_cnt / stall_cnt saturating counters.
module rr_mux_arbiter_16
    import rr_mux_arbiter_16_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [SEL_W-1:0]          out_sel,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
`ifdef ARB_STATS_EN
    output logic [31:0]               beat_cnt,
    output logic [31:0]               stall_cnt,
`endif
    input  logic                      out_ready
);
    localparam bit LOCK_EN = (MAX_HOLD > 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   last_grant;
    logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
    logic [SEL_W-1:0]   rr_idx, winner;
    logic               rr_any;
    logic               slot_free, cap, pinned;
    logic [DATA_W-1:0]  mux_out;

    rr_pick16 u_pick (
        .req   (req),
        .start (last_grant + 4'd1),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    // Lock keeps the grant only while the holder still requests
    // and has beats left; otherwise fall back to round-robin now.
    assign pinned    = (state == LOCK) && req[last_grant]
                       && (hold_cnt < HOLD_MAX);
    assign winner    = pinned ? last_grant : rr_idx;
    assign slot_free = !out_valid || out_ready;
    assign cap       = rst_n && rr_any && slot_free;

    mux_16to1_32bit #(.W(DATA_W)) u_mux (
        .data (req_data),
        .ctrl (winner),
        .out  (mux_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        unique case (1'b1)
            cap: begin
                if (LOCK_EN && lock[winner]) begin
                    state_nxt = LOCK;
                    hold_nxt  = pinned ? hold_cnt + 1'b1 : HOLD_W'(1);
                end else begin
                    state_nxt = BUSY;
                    hold_nxt  = '0;
                end
            end
            (!cap && out_ready): begin
                state_nxt = IDLE;
                hold_nxt  = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        gnt = '0;
        if (cap) gnt[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= '0;
            last_grant <= SEL_W'(NUM_REQ - 1);
        end else if (cap) begin
            out_valid  <= 1'b1;
            out_data   <= mux_out;
            out_sel    <= winner;
            last_grant <= winner;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && out_ready && beat_cnt != '1)
                beat_cnt <= beat_cnt + 1'b1;
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_rr_mux_arbiter_16.sv
// Self-checking bench for rr_mux_arbiter_16 (MAX_HOLD=3).
// Table of vectors with hand-derived grants, plus a data scoreboard.
module tb_rr_mux_arbiter_16;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  req, lock, gnt;
    logic [511:0] req_data;
    logic [3:0]   out_sel;
    logic [31:0]  out_data;
    logic         out_valid, out_ready;
`ifdef ARB_STATS_EN
    logic [31:0]  beat_cnt, stall_cnt;
`endif

    logic [31:0] lanes [16];

    typedef struct {
        logic [15:0] req;
        logic [15:0] lock;
        logic        ready;
        logic [15:0] gnt;
        logic        valid;
    } vec_t;

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] data;
    } exp_t;

    vec_t tbl[$];
    exp_t q[$];
    exp_t held;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < 16; i++)
            req_data[i*32 +: 32] = lanes[i];
    end

    rr_mux_arbiter_16 #(.DATA_W(32), .MAX_HOLD(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .lock      (lock),
        .req_data  (req_data),
        .gnt       (gnt),
        .out_sel   (out_sel),
        .out_data  (out_data),
        .out_valid (out_valid),
`ifdef ARB_STATS_EN
        .beat_cnt  (beat_cnt),
        .stall_cnt (stall_cnt),
`endif
        .out_ready (out_ready)
    );

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] oh2i(input logic [15:0] v);
        oh2i = '0;
        for (int i = 0; i < 16; i++)
            if (v[i]) oh2i = 4'(i);
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        req       = v.req;
        lock      = v.lock;
        out_ready = v.ready;
        #1;
        cmp("gnt", 32'(gnt), 32'(v.gnt));
        if (v.gnt != 0)
            q.push_back('{sel: oh2i(v.gnt), data: lanes[oh2i(v.gnt)]});
        @(posedge clk);
        #1;
        cmp("out_valid", 32'(out_valid), 32'(v.valid));
        if (v.gnt != 0) begin
            if (q.size() == 0) begin
                cmp("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                cmp("out_sel", 32'(out_sel), 32'(e.sel));
                cmp("out_data", out_data, e.data);
                held = e;
            end
        end else if (v.valid) begin
            cmp("hold_sel", 32'(out_sel), 32'(held.sel));
            cmp("hold_data", out_data, held.data);
        end
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++)
            lanes[i] = 32'h0101_0101 * 32'(i + 1);
        lanes[3] = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        req = '0;
        lock = '0;
        out_ready = 1'b0;
        held = '0;
        #1;
        cmp("rst_valid", 32'(out_valid), 32'd0);
        cmp("rst_sel", 32'(out_sel), 32'd0);
        cmp("rst_data", out_data, 32'd0);
        cmp("rst_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // alternation 0,4,0,4 from reset
        tbl.push_back('{16'h0011, 16'h0, 1'b1, 16'h0001, 1'b1});
        tbl.push_back('{16'h0011, 16'h0, 1'b1, 16'h0010, 1'b1});
        tbl.push_back('{16'h0011, 16'h0, 1'b1, 16'h0001, 1'b1});
        tbl.push_back('{16'h0011, 16'h0, 1'b1, 16'h0010, 1'b1});
        tbl.push_back('{16'h0000, 16'h0, 1'b1, 16'h0000, 1'b0});
        // wrap-around 15 -> 0 -> 15
        tbl.push_back('{16'h8000, 16'h0, 1'b1, 16'h8000, 1'b1});
        tbl.push_back('{16'h8001, 16'h0, 1'b1, 16'h0001, 1'b1});
        tbl.push_back('{16'h8001, 16'h0, 1'b1, 16'h8000, 1'b1});
        tbl.push_back('{16'h0000, 16'h0, 1'b1, 16'h0000, 1'b0});
        // capture DEADBEEF then 5 stall cycles
        tbl.push_back('{16'h0008, 16'h0, 1'b1, 16'h0008, 1'b1});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{16'h0008, 16'h0, 1'b0, 16'h0000, 1'b1});
        tbl.push_back('{16'h0000, 16'h0, 1'b1, 16'h0000, 1'b0});
        tbl.push_back('{16'h0002, 16'h0, 1'b1, 16'h0002, 1'b1});
        tbl.push_back('{16'h0000, 16'h0, 1'b1, 16'h0000, 1'b0});
        // lock on 2: three beats, then 5, then 2 again
        tbl.push_back('{16'h0024, 16'h0004, 1'b1, 16'h0004, 1'b1});
        tbl.push_back('{16'h0024, 16'h0004, 1'b1, 16'h0004, 1'b1});
        tbl.push_back('{16'h0024, 16'h0004, 1'b1, 16'h0004, 1'b1});
        tbl.push_back('{16'h0024, 16'h0004, 1'b1, 16'h0020, 1'b1});
        tbl.push_back('{16'h0024, 16'h0004, 1'b1, 16'h0004, 1'b1});
        // holder drops req: same-cycle round-robin
        tbl.push_back('{16'h0020, 16'h0004, 1'b1, 16'h0020, 1'b1});
        tbl.push_back('{16'h0000, 16'h0, 1'b1, 16'h0000, 1'b0});
        // holder drops lock at a capture
        tbl.push_back('{16'h0024, 16'h0004, 1'b1, 16'h0004, 1'b1});
        tbl.push_back('{16'h0024, 16'h0000, 1'b1, 16'h0004, 1'b1});
        tbl.push_back('{16'h0024, 16'h0000, 1'b1, 16'h0020, 1'b1});
        tbl.push_back('{16'h0024, 16'h0000, 1'b1, 16'h0004, 1'b1});
        // lock on 5, stall, then reset below
        tbl.push_back('{16'h0020, 16'h0020, 1'b1, 16'h0020, 1'b1});
        tbl.push_back('{16'h0020, 16'h0020, 1'b0, 16'h0000, 1'b1});
        run_tbl();

        // async reset while valid and locked
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        cmp("midrst_valid", 32'(out_valid), 32'd0);
        cmp("midrst_sel", 32'(out_sel), 32'd0);
        cmp("midrst_data", out_data, 32'd0);
        cmp("midrst_gnt", 32'(gnt), 32'd0);
        req = '0;
        lock = '0;
        held = '0;
        q.delete();
        #1;
        rst_n = 1'b1;
        // scan restarts at 0 (not pinned to 5, not from 6)
        tbl.push_back('{16'h0202, 16'h0, 1'b1, 16'h0002, 1'b1});
        tbl.push_back('{16'h0000, 16'h0, 1'b1, 16'h0000, 1'b0});
        run_tbl();

`ifdef ARB_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        cmp("stat_rst_beat", beat_cnt, 32'd0);
        cmp("stat_rst_stall", stall_cnt, 32'd0);
        rst_n = 1'b1;
        held = '0;
        for (int i = 0; i < 10; i++)
            tbl.push_back('{16'h0001, 16'h0, 1'b1, 16'h0001, 1'b1});
        for (int i = 0; i < 4; i++)
            tbl.push_back('{16'h0001, 16'h0, 1'b0, 16'h0000, 1'b1});
        tbl.push_back('{16'h0000, 16'h0, 1'b1, 16'h0000, 1'b0});
        run_tbl();
        cmp("beat_cnt", beat_cnt, 32'd10);
        cmp("stall_cnt", stall_cnt, 32'd4);
`endif

        cmp("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_mux_arbiter_16.md
Name: rr_mux_arbiter_16

Overview:
- Round-robin arbiter that shares one 16:1 32-bit select path among 16 requesters.
- Picks a winner, drives the 4-bit select and captures the selected word into an output register with a valid/ready handshake.
- Sits between multiple producers (CSR/debug/peripheral read sources) and a single consumer port in the processor.
- Supports an optional per-requester lock that holds the grant for a bounded number of beats.

Parameters:
- DATA_W, 32: width of each requester word and of out_data.
- NUM_REQ, 16: requester count; fixed at 16 to match the 4-bit select.
- MAX_HOLD, 8: maximum consecutive beats a locked requester keeps the grant; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  16  request per requester; bit i = requester i.
- lock  in  16  hold request; lock[i] is only sampled when i wins.
- req_data  in  16*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- gnt  out  16  one-hot combinational grant; high in the cycle requester i's word is captured.
- out_sel  out  4  index of the word held in out_data.
- out_data  out  DATA_W  registered selected word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_sel=0, last_grant=15, hold_cnt=0, state=IDLE, gnt=0. Reset mid-transfer drops any pending word.
- Capture condition: cap = (|req) && (!out_valid || out_ready). Back-to-back transfers at 1 word/cycle are allowed.
- Winner when not locked: first set bit of req, scanning last_grant+1, +2, … with mod-16 wrap.
  - After reset the scan starts at 0.
  - If only last_grant requests, it wins again.
- Capture cycle:
  - gnt[winner]=1, all other gnt bits 0.
  - On the next edge: out_data=req_data[winner], out_sel=winner, out_valid=1, last_grant=winner.
- Latency: req high with the slot free produces out_valid on the next edge.
- No capture, out_valid=1, out_ready=0: out_data and out_sel are held stable and gnt=0.
- No capture, out_ready=1: out_valid goes to 0.
- States:
  - IDLE: out_valid=0.
  - BUSY: out_valid=1, no lock held.
  - LOCK: out_valid=1 or 0, grant pinned to last_grant.
- Transitions:
  - IDLE to BUSY on cap with lock[winner]=0.
  - IDLE or BUSY to LOCK on cap with lock[winner]=1 and MAX_HOLD>1; hold_cnt is set to 1.
  - In LOCK, the next capture goes only to last_grant, and only if req[last_grant]=1. Each such capture increments hold_cnt.
  - LOCK exits to round-robin when any of these occurs:
    - req[last_grant]=0 at a capture opportunity; other requesters are then arbitrated in the same cycle.
    - lock[last_grant]=0 at a capture.
    - hold_cnt reaches MAX_HOLD; the next capture scans from last_grant+1.
  - BUSY or LOCK to IDLE when out_valid clears.
- gnt is never asserted when req is 0. At most one gnt bit is high per cycle.
- req_data of non-winners is ignored. X on unselected lanes must not propagate.

Optional Feature:
- Macro ARB_STATS_EN adds two ports:
  - beat_cnt, out, 32: counts cycles with out_valid && out_ready.
  - stall_cnt, out, 32: counts cycles with out_valid && !out_ready.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Without the macro, neither the ports nor the counter logic exist.

Decomposition:
- Shared package holds:
  - constants NUM_REQ=16 and SEL_W=4;
  - state encodings IDLE=2'd0, BUSY=2'd1, LOCK=2'd2;
  - MAX_HOLD default.
- Word selection reuses the existing mux_16to1_32bit instance, with ctrl driven by the combinational winner index.
- One new sub-module, rr_pick16, is natural: purely combinational. Inputs req[15:0] and start[3:0]; outputs idx[3:0] and any.

Test Plan:
- After reset, req=16'h0011, out_ready=1: gnt=0x0001 and then 0x0010 on alternate cycles; out_sel sequence 0,4,0,4.
- req=16'h8001 with last_grant=15: winner 0. Then with last_grant=0: winner 15. Checks wrap-around.
- Capture of data 0xDEADBEEF from req 3, then out_ready=0 for 5 cycles: out_data holds 0xDEADBEEF, out_valid stays 1, gnt=0 throughout.
- MAX_HOLD=3, req=16'h0024, lock[2]=1: three beats from requester 2, then requester 5, then requester 2 again.
- rst_n pulled low while out_valid=1 and in LOCK: out_valid drops immediately; first grant after release scans from 0.
- With ARB_STATS_EN, 10 accepted beats and 4 stall cycles: beat_cnt=10, stall_cnt=4.
